// File: rtl/com_receiver.sv
`default_nettype none
// ============================================================================
// Module      : com_receiver
// Description : Receives bytes from an external interpreter on an 8-bit bus
//               qualified by an asynchronous strobe. It packs every four bytes
//               little-endian into a 32-bit word and writes the words
//               sequentially into data memory ahead of CPU start-up.
// Revision    : 1.0 - initial release
// ============================================================================
module com_receiver #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_WORDS   = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Enable,
  input  logic        clk_in,
  input  logic [7:0]  DataIn,
  output logic        MemWrite,
  output logic [31:0] DataAddress,
  output logic [31:0] WriteData,
  output logic        Busy,
  output logic        LoadDone,
  output logic [1:0]  ByteCount
);

  localparam int c_WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [c_WIDX_W-1:0] c_LAST_IDX = c_WIDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic [SYNC_STAGES:0]   r_warm;
  logic [31:0]            r_asm;
  logic [1:0]             r_byte_idx;
  logic [c_WIDX_W-1:0]    r_word_idx;
  logic                   r_ready;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;

  logic                   w_sync_out;
  logic                   w_rise;
  logic                   w_last_word;
  logic                   w_capture;
  logic                   w_enter_write;
  logic [31:0]            w_addr;

  // r_warm gates edge detection until r_sync_prev holds a genuine sample, so
  // a strobe already high when reset is released is never seen as a rise.
  assign w_sync_out    = r_sync[SYNC_STAGES-1];
  assign w_rise        = w_sync_out & ~r_sync_prev & r_warm[SYNC_STAGES];
  assign w_last_word   = (r_word_idx == c_LAST_IDX);
  // A rise during the write cycle becomes byte 0 of the following word.
  assign w_capture     = w_rise & Enable &
                         ((r_state == S_RECV) | ((r_state == S_WRITE) & ~w_last_word));
  assign w_enter_write = (r_state == S_RECV) & Enable & r_ready;
  assign w_addr        = BASE_ADDR + (32'(r_word_idx) << 2);

  // Synchronize the external strobe and keep the previous sample for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_warm      <= '0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], clk_in};
      r_sync_prev <= w_sync_out;
      r_warm      <= {r_warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next   = r_state;
    MemWrite = 1'b0;
    Busy     = 1'b0;
    LoadDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Enable) w_next = S_RECV;
      end
      S_RECV: begin
        Busy = 1'b1;
        if (!Enable)      w_next = S_IDLE;
        else if (r_ready) w_next = S_WRITE;
      end
      S_WRITE: begin
        Busy     = 1'b1;
        MemWrite = 1'b1;
        if (!Enable)          w_next = S_IDLE;
        else if (w_last_word) w_next = S_DONE;
        else                  w_next = S_RECV;
      end
      S_DONE: begin
        LoadDone = 1'b1;
        if (!Enable) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Byte assembly, word indexing and the held write address/data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm      <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_ready    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_ready <= 1'b0;
      if (r_state == S_IDLE) begin
        r_byte_idx <= '0;
        r_word_idx <= '0;
      end
      if (w_capture) begin
        r_asm[{r_byte_idx, 3'b000} +: 8] <= DataIn;
        r_byte_idx <= r_byte_idx + 2'd1;
        r_ready    <= (r_byte_idx == 2'd3);
      end
      if (w_enter_write) begin
        r_wdata <= r_asm;
        r_addr  <= w_addr;
      end
      if ((r_state == S_WRITE) && Enable && !w_last_word) begin
        r_word_idx <= r_word_idx + c_WIDX_W'(1);
      end
    end
  end

  assign DataAddress = r_addr;
  assign WriteData   = r_wdata;
  assign ByteCount   = r_byte_idx;

endmodule
`default_nettype wire
